// File: rtl/viti_pkg.sv
// Shared definitions for the VITI command receiver.
// Holds the frame constants, the parser and run-FSM state encodings and the
// frame checksum helper used by the parser.
package viti_pkg;

  localparam logic [7:0] SYNC      = 8'hA5;
  localparam logic [7:0] OPC_START = 8'h01;
  localparam logic [7:0] OPC_ABORT = 8'h02;

  typedef enum logic [1:0] {
    P_HUNT,
    P_OPC,
    P_ARG,
    P_CHK
  } parser_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_TRIG,
    R_WAIT_DONE
  } run_state_e;

  // Checksum byte a well-formed frame must carry.
  function automatic logic [7:0] frame_chk(input logic [7:0] opc, input logic [7:0] arg);
    return SYNC ^ opc ^ arg;
  endfunction

endpackage

// File: rtl/viti_frame_parser.sv
// Four-byte frame parser: SYNC, OPC, ARG, CHK.
// Ports:
//   clk, reset   - rising-edge clock, synchronous active-high reset
//   byte_valid   - one-cycle strobe for byte_data
//   byte_data    - received byte
//   flush        - inter-byte timeout; returns the parser to P_HUNT and
//                  discards any byte presented in the same cycle
//   state        - current parser state (drives the inter-byte timer)
//   frame_valid  - strobe, same cycle as the CHK byte, checksum matched;
//                  opc/arg hold the frame contents while it is high
//   frame_bad    - strobe, same cycle as the CHK byte, checksum mismatch
//   opc, arg     - captured opcode and argument bytes
module viti_frame_parser
  import viti_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  input  logic          flush,
  output parser_state_e state,
  output logic          frame_valid,
  output logic          frame_bad,
  output logic [7:0]    opc,
  output logic [7:0]    arg
);

  parser_state_e state_q, state_d;
  logic [7:0]    opc_q, arg_q;
  logic          take;

  assign take  = byte_valid && !flush;
  assign state = state_q;
  assign opc   = opc_q;
  assign arg   = arg_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= P_HUNT;
      opc_q   <= '0;
      arg_q   <= '0;
    end else begin
      state_q <= state_d;
      if (take && state_q == P_OPC) opc_q <= byte_data;
      if (take && state_q == P_ARG) arg_q <= byte_data;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d     = state_q;
    frame_valid = 1'b0;
    frame_bad   = 1'b0;
    if (flush) begin
      state_d = P_HUNT;
    end else if (byte_valid) begin
      unique case (state_q)
        P_HUNT: if (byte_data == SYNC) state_d = P_OPC;
        // Once synced, every byte is payload, SYNC included: no resync.
        P_OPC:  state_d = P_ARG;
        P_ARG:  state_d = P_CHK;
        P_CHK: begin
          state_d = P_HUNT;
          if (byte_data == frame_chk(opc_q, arg_q)) frame_valid = 1'b1;
          else                                      frame_bad   = 1'b1;
        end
        default: state_d = P_HUNT;
      endcase
    end
  end

endmodule

// File: rtl/viti_cmd_rx.sv
// UART command receiver driving a burst of capture runs.
// A START frame launches N trigger/busy handshakes with the capture engine;
// ABORT stops the burst after the run in progress.
// Ports:
//   clk, reset     - rising-edge clock, synchronous active-high reset
//   uart_rx_DV     - one-cycle strobe for uart_rx_Byte
//   uart_rx_Byte   - received byte
//   busy           - capture/transfer engine busy flag
//   sampling_trig  - trigger level, high only in R_TRIG
//   run_active     - burst in progress
//   runs_done      - runs completed in the current or last burst
//   cmd_ok         - one-cycle pulse, frame accepted
//   cmd_reject     - one-cycle pulse, bad/unknown/disallowed frame or timeout
//   err_count      - saturating count of cmd_reject pulses
module viti_cmd_rx
  import viti_pkg::*;
#(
  parameter int BYTE_TIMEOUT = 96000,
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx_DV,
  input  logic [7:0] uart_rx_Byte,
  input  logic       busy,
  output logic       sampling_trig,
  output logic       run_active,
  output logic [7:0] runs_done,
  output logic       cmd_ok,
  output logic       cmd_reject,
  output logic [7:0] err_count
);

  localparam int GAP_W = $clog2(BYTE_TIMEOUT + 1);
  localparam int BSY_W = $clog2(BUSY_TIMEOUT + 1);

  parser_state_e p_state;
  logic          frame_valid, frame_bad;
  logic [7:0]    opc, arg;

  run_state_e    run_q, run_d;
  logic [7:0]    remaining;
  logic          abort_pend;
  logic          rej_pend;
  logic [GAP_W-1:0] gap_cnt;
  logic [BSY_W-1:0] busy_cnt;

  logic byte_timeout, busy_timeout, run_done;
  logic start_acc, abort_acc, ok_evt, rej_evt;

  // The timeout is presented as a flush so it wins over a coincident byte.
  viti_frame_parser u_parser (
    .clk         (clk),
    .reset       (reset),
    .byte_valid  (uart_rx_DV),
    .byte_data   (uart_rx_Byte),
    .flush       (byte_timeout),
    .state       (p_state),
    .frame_valid (frame_valid),
    .frame_bad   (frame_bad),
    .opc         (opc),
    .arg         (arg)
  );

  assign run_active    = (run_q != R_IDLE);
  assign sampling_trig = (run_q == R_TRIG);

  // gap_cnt counts idle cycles since the last byte of a partial frame; when
  // it has reached BYTE_TIMEOUT, the next cycle without a byte is too late.
  assign byte_timeout = (p_state != P_HUNT) && (gap_cnt == GAP_W'(BYTE_TIMEOUT));

  // Trigger has been high for BUSY_TIMEOUT cycles once this fires.
  assign busy_timeout = (run_q == R_TRIG) && !busy &&
                        (busy_cnt == BSY_W'(BUSY_TIMEOUT - 1));

  assign start_acc = frame_valid && (opc == OPC_START) && (arg != 8'd0) && !run_active;
  assign abort_acc = frame_valid && (opc == OPC_ABORT);
  assign ok_evt    = start_acc || abort_acc;
  assign rej_evt   = (frame_valid && !ok_evt) || frame_bad || byte_timeout ||
                     busy_timeout || rej_pend;

  always_comb begin
    run_d    = run_q;
    run_done = 1'b0;
    unique case (run_q)
      R_IDLE: if (start_acc) run_d = R_TRIG;
      R_TRIG: begin
        if (busy)              run_d = R_WAIT_DONE;
        else if (busy_timeout) run_d = R_IDLE;
      end
      R_WAIT_DONE: begin
        if (!busy) begin
          run_done = 1'b1;
          // An ABORT landing in this very cycle still counts as pending.
          if (remaining > 8'd1 && !(abort_pend || abort_acc)) run_d = R_TRIG;
          else                                                run_d = R_IDLE;
        end
      end
      default: run_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q      <= R_IDLE;
      remaining  <= '0;
      runs_done  <= '0;
      abort_pend <= 1'b0;
      rej_pend   <= 1'b0;
      gap_cnt    <= '0;
      busy_cnt   <= '0;
      cmd_ok     <= 1'b0;
      cmd_reject <= 1'b0;
      err_count  <= '0;
    end else begin
      run_q <= run_d;

      if (start_acc) begin
        remaining <= arg;
        runs_done <= '0;
      end else if (run_done) begin
        // runs_done never exceeds the loaded N, so it cannot wrap.
        remaining <= remaining - 8'd1;
        runs_done <= runs_done + 8'd1;
      end

      if (run_d == R_IDLE)  abort_pend <= 1'b0;
      else if (abort_acc)   abort_pend <= 1'b1;

      if (p_state == P_HUNT || uart_rx_DV || byte_timeout) gap_cnt <= '0;
      else                                                 gap_cnt <= gap_cnt + 1'b1;

      if (run_q == R_TRIG && run_d == R_TRIG) busy_cnt <= busy_cnt + 1'b1;
      else                                    busy_cnt <= '0;

      // cmd_ok and cmd_reject are never raised together: a timeout that
      // coincides with an accepted frame is reported one cycle later.
      cmd_ok <= ok_evt;
      if (ok_evt) begin
        cmd_reject <= 1'b0;
        rej_pend   <= rej_evt;
      end else begin
        cmd_reject <= rej_evt;
        rej_pend   <= 1'b0;
        if (rej_evt && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_viti_cmd_rx.sv
// Self-checking bench for viti_cmd_rx. Expected cmd_ok/cmd_reject responses
// (kind and arrival cycle) are queued when frames are sent and compared when
// the DUT pulses. A simple busy model answers each trigger.
module tb_viti_cmd_rx;
  import viti_pkg::*;

  localparam int BT      = 64;
  localparam int BST     = 40;
  localparam int BUSY_HI = 300;

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_rx_DV;
  logic [7:0] uart_rx_Byte;
  logic       busy;
  logic       sampling_trig;
  logic       run_active;
  logic [7:0] runs_done;
  logic       cmd_ok;
  logic       cmd_reject;
  logic [7:0] err_count;

  viti_cmd_rx #(.BYTE_TIMEOUT(BT), .BUSY_TIMEOUT(BST)) dut (
    .clk           (clk),
    .reset         (reset),
    .uart_rx_DV    (uart_rx_DV),
    .uart_rx_Byte  (uart_rx_Byte),
    .busy          (busy),
    .sampling_trig (sampling_trig),
    .run_active    (run_active),
    .runs_done     (runs_done),
    .cmd_ok        (cmd_ok),
    .cmd_reject    (cmd_reject),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 1 = cmd_ok, 2 = cmd_reject; at: cycle the pulse must be seen, -1 = any
  typedef struct {
    int kind;
    int at;
  } exp_t;
  exp_t sb[$];

  bit busy_en   = 1'b1;
  int trig_rise = 0;
  int trig_hi   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Busy model: rises two cycles after a trigger is seen, stays high BUSY_HI cycles.
  initial begin
    busy = 1'b0;
    forever begin
      @(negedge clk);
      if (busy_en && sampling_trig && !busy) begin
        repeat (2) @(negedge clk);
        busy = 1'b1;
        repeat (BUSY_HI) @(negedge clk);
        busy = 1'b0;
      end
    end
  end

  // Response monitor and trigger statistics.
  initial begin
    logic trig_prev;
    exp_t e;
    int   kind;
    trig_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (sampling_trig && !trig_prev) trig_rise++;
      if (sampling_trig) trig_hi++;
      trig_prev = sampling_trig;
      if (cmd_ok || cmd_reject) begin
        check("resp_exclusive", cmd_ok & cmd_reject, 0);
        kind = cmd_ok ? 1 : 2;
        if (sb.size() == 0) begin
          check("unexpected_resp", kind, 0);
        end else begin
          e = sb.pop_front();
          check("resp_kind", kind, e.kind);
          if (e.at >= 0) check("resp_cycle", cyc, e.at);
        end
      end
    end
  end

  // Called on a falling edge; returns on the next falling edge.
  task automatic send_byte(input logic [7:0] b);
    uart_rx_DV   = 1'b1;
    uart_rx_Byte = b;
    @(negedge clk);
    uart_rx_DV   = 1'b0;
  endtask

  // kind 0 means no response is expected; at returns the expected response cycle.
  task automatic send_frame(input logic [7:0] o, input logic [7:0] a, input logic [7:0] c,
                            input int kind, output int at);
    send_byte(SYNC);
    send_byte(o);
    send_byte(a);
    at = cyc + 1;
    if (kind != 0) sb.push_back('{kind: kind, at: at});
    send_byte(c);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (run_active && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, run_active, 0);
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, sb.size(), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, h0, at, c, n;
    reset        = 1'b1;
    uart_rx_DV   = 1'b0;
    uart_rx_Byte = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_trig",   sampling_trig, 0);
    check("rst_active", run_active, 0);
    check("rst_runs",   runs_done, 0);
    check("rst_ok",     cmd_ok, 0);
    check("rst_rej",    cmd_reject, 0);
    check("rst_err",    err_count, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Three-run burst.
    r0 = trig_rise;
    send_frame(OPC_START, 8'h03, 8'hA7, 1, at);
    check("t1_active", run_active, 1);
    wait_idle(5000, "t1_idle");
    check("t1_runs",  runs_done, 3);
    check("t1_trigs", trig_rise - r0, 3);
    check("t1_err",   err_count, 0);

    // Bad checksum.
    r0 = trig_rise;
    send_frame(OPC_START, 8'h03, 8'h00, 2, at);
    repeat (20) @(negedge clk);
    check("t2_err",    err_count, 1);
    check("t2_trigs",  trig_rise - r0, 0);
    check("t2_active", run_active, 0);

    // ABORT during run 2 of 5.
    r0 = trig_rise;
    send_frame(OPC_START, 8'h05, 8'hA1, 1, at);
    n = 0;
    while (!(runs_done == 8'd1 && busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t3_in_run2", runs_done == 8'd1 && busy, 1);
    send_frame(OPC_ABORT, 8'h00, 8'hA7, 1, at);
    wait_idle(5000, "t3_idle");
    check("t3_runs",  runs_done, 2);
    check("t3_trigs", trig_rise - r0, 2);

    // START while a burst runs is rejected and does not disturb it.
    send_frame(OPC_START, 8'h02, 8'hA6, 1, at);
    repeat (10) @(negedge clk);
    check("t4_active", run_active, 1);
    send_frame(OPC_START, 8'h03, 8'hA7, 2, at);
    wait_idle(5000, "t4_idle");
    check("t4_runs", runs_done, 2);
    check("t4_err",  err_count, 2);

    // Unknown opcode with valid checksum, and START with N=0.
    send_frame(8'h03, 8'h00, 8'hA6, 2, at);
    send_frame(OPC_START, 8'h00, 8'hA4, 2, at);
    wait_drain(20, "t4b_drain");
    check("t4b_err",    err_count, 4);
    check("t4b_active", run_active, 0);

    // Inter-byte timeout after A5 01.
    send_byte(SYNC);
    send_byte(OPC_START);
    c = cyc;
    sb.push_back('{kind: 2, at: c + BT + 1});
    wait_drain(BT + 20, "t5_drain");
    check("t5_hunt", dut.p_state == P_HUNT, 1);
    check("t5_err",  err_count, 5);
    send_frame(OPC_ABORT, 8'h00, 8'hA7, 1, at);
    wait_drain(10, "t5_next_ok");
    check("t5_idle_abort", run_active, 0);

    // Timeout in the same cycle as a byte: the byte is dropped.
    send_byte(SYNC);
    send_byte(OPC_START);
    c = cyc;
    sb.push_back('{kind: 2, at: c + BT + 1});
    repeat (BT) @(negedge clk);
    send_byte(SYNC);
    send_byte(OPC_ABORT);
    send_byte(8'h00);
    send_byte(8'hA7);
    repeat (20) @(negedge clk);
    check("t5b_drain", sb.size(), 0);
    check("t5b_err",   err_count, 6);

    // Busy never rises: trigger held BST cycles, then reject.
    busy_en = 1'b0;
    repeat (5) @(negedge clk);
    h0 = trig_hi;
    send_frame(OPC_START, 8'h01, 8'hA5, 1, at);
    sb.push_back('{kind: 2, at: at + BST});
    wait_drain(BST + 50, "t6_drain");
    check("t6_trig_len", trig_hi - h0, BST);
    check("t6_active",   run_active, 0);
    check("t6_err",      err_count, 7);
    check("t6_runs",     runs_done, 0);

    // Reset mid-burst.
    busy_en = 1'b1;
    send_frame(OPC_START, 8'h03, 8'hA7, 1, at);
    wait_drain(10, "t7_drain");
    check("t7_trig_on", sampling_trig, 1);
    reset = 1'b1;
    @(negedge clk);
    check("t7_trig_off", sampling_trig, 0);
    check("t7_active",   run_active, 0);
    check("t7_runs",     runs_done, 0);
    check("t7_err",      err_count, 0);
    reset = 1'b0;
    r0 = trig_rise;
    repeat (400) @(negedge clk);
    check("t7_no_trig", trig_rise - r0, 0);
    check("final_drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/viti_cmd_rx.md
VITI_CMD_RX -- requirements
Module: viti_cmd_rx

Interface
REQ-001 SHALL have parameter BYTE_TIMEOUT, default 96000, meaning the maximum clk cycles allowed between bytes of one frame.
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 1024, meaning the maximum clk cycles from trigger assertion until busy is seen high.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port uart_rx_DV, input, 1 bit: one-cycle strobe marking a valid received byte.
REQ-006 SHALL have port uart_rx_Byte, input, 8 bits: received byte, valid while uart_rx_DV=1.
REQ-007 SHALL have port busy, input, 1 bit: capture/transfer engine busy flag.
REQ-008 SHALL have port sampling_trig, output, 1 bit: trigger level to the capture engine.
REQ-009 SHALL have port run_active, output, 1 bit: high while a burst is in progress.
REQ-010 SHALL have port runs_done, output, 8 bits: runs completed in the current or last burst.
REQ-011 SHALL have port cmd_ok, output, 1 bit: one-cycle pulse when a frame is accepted.
REQ-012 SHALL have port cmd_reject, output, 1 bit: one-cycle pulse on a bad, unknown or disallowed frame, or a timeout.
REQ-013 SHALL have port err_count, output, 8 bits: count of cmd_reject pulses, saturating at 255.

Function
REQ-014 SHALL parse frames of four bytes: 0xA5, OPC, ARG, CHK, where CHK = 0xA5 XOR OPC XOR ARG.
REQ-015 SHALL implement parser states P_HUNT, P_OPC, P_ARG, P_CHK.
REQ-016 SHALL, in P_HUNT, discard every byte except 0xA5; 0xA5 moves the parser to P_OPC.
REQ-017 SHALL treat every byte in P_OPC, P_ARG and P_CHK as data, including 0xA5; there is no mid-frame resync.
REQ-018 SHALL, when the inter-byte gap exceeds BYTE_TIMEOUT cycles outside P_HUNT, return the parser to P_HUNT and pulse cmd_reject.
REQ-019 SHALL, on a CHK mismatch, pulse cmd_reject and return the parser to P_HUNT.
REQ-020 SHALL treat OPC 0x01 as START with ARG = N runs, N from 1 to 255.
REQ-021 SHALL reject START if N=0 or if run_active=1.
REQ-022 SHALL treat OPC 0x02 as ABORT: no further runs are issued after the current run finishes; ABORT while idle is accepted as a no-op.
REQ-023 SHALL reject any other OPC, even when CHK is valid.
REQ-024 SHALL assert cmd_ok or cmd_reject exactly one cycle after the CHK byte strobe, and never both in the same cycle.
REQ-025 SHALL implement run states R_IDLE, R_TRIG, R_WAIT_DONE.
REQ-026 SHALL, on an accepted START, load remaining=N, clear runs_done, set run_active=1 and enter R_TRIG on the same cycle cmd_ok is asserted.
REQ-027 SHALL, in R_TRIG, hold sampling_trig=1 until busy=1 is sampled, then drop sampling_trig on the next cycle and enter R_WAIT_DONE.
REQ-028 SHALL, in R_TRIG, if busy is not seen within BUSY_TIMEOUT cycles, drop sampling_trig, pulse cmd_reject, end the burst and go to R_IDLE.
REQ-029 SHALL, in R_WAIT_DONE, on busy=0: increment runs_done, decrement remaining, then go to R_TRIG if remaining>0 and no abort is pending, otherwise go to R_IDLE with run_active=0.
REQ-030 SHALL never assert sampling_trig outside R_TRIG.
REQ-031 SHALL, when a byte strobe coincides with a run-FSM transition, handle both independently with no byte loss.
REQ-032 SHALL, when a timeout and a byte strobe occur in the same cycle, give the timeout priority and drop the byte.
REQ-033 SHALL keep the 8-bit counters free of wrap-around: runs_done is at most 255 and err_count saturates at 255.

Reset
REQ-034 SHALL, on reset=1 at a clk edge: parser to P_HUNT, run FSM to R_IDLE, sampling_trig=0, run_active=0, runs_done=0, cmd_ok=0, cmd_reject=0, err_count=0, timers cleared, abort flag cleared.
REQ-035 SHALL, on reset mid-burst, drop sampling_trig on the next edge and issue no further triggers.

Structure
REQ-036 SHALL place the constants SYNC=0xA5, OPC_START=0x01 and OPC_ABORT=0x02, plus the parser and run state encodings, in the shared package viti_pkg.
REQ-037 SHALL implement frame parsing in one sub-module, viti_frame_parser, which outputs an opcode/argument valid strobe and a bad-frame strobe.
REQ-038 SHALL keep the run FSM, counters and timers in viti_cmd_rx.

Verification
REQ-039 SHALL cover: frame A5 01 03 A7 with a busy model (high 2 cycles after trig, low 300 cycles later) -> cmd_ok, three trig/busy cycles, runs_done=3, run_active=0.
REQ-040 SHALL cover: frame A5 01 03 00 -> cmd_reject, err_count=1, no sampling_trig.
REQ-041 SHALL cover: START N=5, then A5 02 00 A7 during run 2 -> runs_done=2, run_active=0.
REQ-042 SHALL cover: START while run_active=1 -> cmd_reject, burst unaffected.
REQ-043 SHALL cover: A5 01 with no further bytes for BYTE_TIMEOUT+1 cycles -> cmd_reject, parser back in P_HUNT, next valid frame accepted.
REQ-044 SHALL cover: START with busy tied to 0 -> sampling_trig high for BUSY_TIMEOUT cycles, then cmd_reject, run_active=0.
